// File: rtl/uart_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_ctrl
// Description : Parses 4-byte sync/addr/data/checksum frames from a UART
//               receiver into config writes, with range, checksum and
//               inter-byte timeout error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_ctrl #(
    parameter int TIMEOUT_CLKS = 56260,
    parameter int ADDR_MAX     = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] i_data_byte,
    input  logic       i_data_avail,
    output logic       o_cfg_wr,
    output logic [7:0] o_cfg_addr,
    output logic [7:0] o_cfg_data,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic [7:0] o_err_count,
    output logic       o_busy
);

    localparam logic [1:0]  ST_SYNC     = 2'd0;
    localparam logic [1:0]  ST_ADDR     = 2'd1;
    localparam logic [1:0]  ST_DATA     = 2'd2;
    localparam logic [1:0]  ST_CSUM     = 2'd3;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam logic [7:0]  ADDR_LIMIT  = 8'(ADDR_MAX);
    localparam logic [23:0] IDLE_LAST   = 24'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]  ERR_CSUM    = 2'b01;
    localparam logic [1:0]  ERR_RANGE   = 2'b10;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [23:0] idle_q, idle_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic [7:0]  cfg_addr_q, cfg_addr_d;
    logic [7:0]  cfg_data_q, cfg_data_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        busy_q, busy_d;

    logic        timeout;
    logic        frame_end;
    logic        csum_ok;

    // A strobe on the terminal-count cycle suppresses the timeout.
    assign timeout   = (state_q != ST_SYNC) && (idle_q == IDLE_LAST) && !i_data_avail;
    assign frame_end = i_data_avail && (state_q == ST_CSUM);
    assign csum_ok   = (i_data_byte == (SYNC_BYTE ^ addr_q ^ data_q));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_data_avail) begin
            case (state_q)
                ST_SYNC: if (i_data_byte == SYNC_BYTE) state_d = ST_ADDR;
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: state_d = ST_CSUM;
                default: state_d = ST_SYNC;
            endcase
        end else if (timeout) begin
            state_d = ST_SYNC;
        end
    end

    always_comb begin
        cfg_wr_d    = 1'b0;
        frame_err_d = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        busy_d      = (state_d != ST_SYNC);
        addr_d      = addr_q;
        data_d      = data_q;

        if (i_data_avail && (state_q == ST_ADDR)) addr_d = i_data_byte;
        if (i_data_avail && (state_q == ST_DATA)) data_d = i_data_byte;

        // Checksum takes priority over the address range check.
        if (frame_end) begin
            if (!csum_ok) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_CSUM;
            end else if (addr_q > ADDR_LIMIT) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_RANGE;
            end else begin
                cfg_wr_d   = 1'b1;
                cfg_addr_d = addr_q;
                cfg_data_d = data_q;
            end
        end else if (timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        if (frame_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

        if (i_data_avail || (state_q == ST_SYNC) || timeout) begin
            idle_d = 24'd0;
        end else begin
            idle_d = idle_q + 24'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q      <= 24'd0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            cfg_wr_q    <= 1'b0;
            cfg_addr_q  <= 8'd0;
            cfg_data_q  <= 8'd0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_count_q <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            idle_q      <= idle_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign o_cfg_wr    = cfg_wr_q;
    assign o_cfg_addr  = cfg_addr_q;
    assign o_cfg_data  = cfg_data_q;
    assign o_frame_err = frame_err_q;
    assign o_err_code  = err_code_q;
    assign o_err_count = err_count_q;
    assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cfg_ctrl
// Description : Scoreboard bench for uart_cfg_ctrl frame parsing and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cfg_ctrl;

    localparam int T    = 100;
    localparam int AMAX = 7;

    logic       clock;
    logic       reset_n;
    logic [7:0] i_data_byte;
    logic       i_data_avail;
    logic       o_cfg_wr;
    logic [7:0] o_cfg_addr;
    logic [7:0] o_cfg_data;
    logic       o_frame_err;
    logic [1:0] o_err_code;
    logic [7:0] o_err_count;
    logic       o_busy;

    uart_cfg_ctrl #(
        .TIMEOUT_CLKS (T),
        .ADDR_MAX     (AMAX)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_data_byte  (i_data_byte),
        .i_data_avail (i_data_avail),
        .o_cfg_wr     (o_cfg_wr),
        .o_cfg_addr   (o_cfg_addr),
        .o_cfg_data   (o_cfg_data),
        .o_frame_err  (o_frame_err),
        .o_err_code   (o_err_code),
        .o_err_count  (o_err_count),
        .o_busy       (o_busy)
    );

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [1:0]  code;
        logic [7:0]  cnt;
        int unsigned cyc;
    } ev_t;

    ev_t         sb[$];
    ev_t         mev;
    int unsigned cyc;
    int unsigned last_e;
    int          n_cmp;
    int          n_bad;
    logic [7:0]  exp_addr, exp_data, exp_cnt;
    logic [1:0]  exp_code;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_data_byte  = b;
        i_data_avail = 1'b1;
        @(posedge clock);
        #1;
        last_e       = cyc;
        i_data_avail = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_err(input logic [1:0] code, input int unsigned at);
        ev_t e;
        exp_code = code;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.is_wr = 1'b0; e.addr = exp_addr; e.data = exp_data;
        e.code  = exp_code; e.cnt = exp_cnt; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int gap);
        ev_t e;
        send(8'hA5); idle(gap);
        send(a);     idle(gap);
        send(d);     idle(gap);
        send(c);
        if (c != (8'hA5 ^ a ^ d)) begin
            push_err(2'b01, last_e);
        end else if (a > 8'(AMAX)) begin
            push_err(2'b10, last_e);
        end else begin
            exp_addr = a;
            exp_data = d;
            e.is_wr = 1'b1; e.addr = a; e.data = d;
            e.code  = exp_code; e.cnt = exp_cnt; e.cyc = last_e;
            sb.push_back(e);
        end
        idle(2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"},   o_cfg_wr, 0);
        chk({tag, "_addr"}, o_cfg_addr, 0);
        chk({tag, "_data"}, o_cfg_data, 0);
        chk({tag, "_err"},  o_frame_err, 0);
        chk({tag, "_code"}, o_err_code, 0);
        chk({tag, "_cnt"},  o_err_count, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    // Event monitor: every write/error pulse must match the head of the queue.
    always @(negedge clock) begin
        if (reset_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("late_evt", cyc, sb[0].cyc);
                sb.delete(0);
            end
            if (o_cfg_wr || o_frame_err) begin
                chk("wr_err_excl", {31'b0, o_cfg_wr & o_frame_err}, 0);
                if (sb.size() == 0) begin
                    chk("unexp_evt", {30'b0, o_cfg_wr, o_frame_err}, 0);
                end else begin
                    mev = sb.pop_front();
                    chk("evt_cyc",  cyc, mev.cyc);
                    chk("evt_wr",   o_cfg_wr, mev.is_wr);
                    chk("evt_err",  o_frame_err, !mev.is_wr);
                    chk("evt_addr", o_cfg_addr, mev.addr);
                    chk("evt_data", o_cfg_data, mev.data);
                    chk("evt_code", o_err_code, mev.code);
                    chk("evt_cnt",  o_err_count, mev.cnt);
                    chk("evt_busy", o_busy, 0);
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        exp_addr = 0; exp_data = 0; exp_cnt = 0; exp_code = 0;
        last_e = 0;
        reset_n = 1'b0; i_data_avail = 1'b0; i_data_byte = 8'h00;
        idle(3);
        chk_all_zero("rst");
        reset_n = 1'b1;
        idle(2);

        send_frame(8'h03, 8'h5C, 8'hFA, 1);
        send_frame(8'h03, 8'h5C, 8'hFB, 1);

        send(8'h00); idle(1);
        send(8'hFF); idle(1);
        chk("sync_idle_busy", o_busy, 0);
        send_frame(8'h08, 8'h11, 8'hBC, 1);

        send(8'hA5); idle(1);
        send(8'h03);
        chk("busy_mid", o_busy, 1);
        push_err(2'b11, last_e + T);
        idle(T + 3);
        send_frame(8'h07, 8'h22, 8'h80, 1);

        send_frame(8'h03, 8'h5C, 8'hFA, T - 1);
        send_frame(8'h09, 8'h00, 8'h00, 1);

        for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h02, 8'h00, 0);
        chk("sat_cnt", o_err_count, 8'hFF);

        send(8'hA5); idle(1);
        send(8'h03); idle(1);
        reset_n = 1'b0;
        #2;
        chk_all_zero("midrst");
        exp_addr = 0; exp_data = 0; exp_cnt = 0; exp_code = 0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send_frame(8'h05, 8'h99, 8'h39, 1);

        idle(5);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
